// File: rtl/fb_scan_palette.sv
// Pixel-domain framebuffer scanner: issues look-ahead reads from the hdmi raster position
// and maps returned iteration indices to RGB through a writable palette, grayscale or cycling palette.
module fb_scan_palette #(
    parameter int unsigned WIDTH        = 1280,
    parameter int unsigned HEIGHT       = 720,
    parameter int unsigned SCALE        = 1,
    parameter int unsigned DATA_BITS    = 4,
    parameter int unsigned RAM_LATENCY  = 1,
    parameter int unsigned CX_BITS      = 11,
    parameter int unsigned CY_BITS      = 10,
    parameter int unsigned CYCLE_FRAMES = 4,
    parameter logic [23:0] BORDER_RGB   = 24'h000000,
    parameter int unsigned ADDR_BITS    = $clog2(WIDTH * HEIGHT)
) (
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    input  logic [CX_BITS-1:0]   cx,
    input  logic [CY_BITS-1:0]   cy,
    input  logic [CX_BITS-1:0]   frame_width,
    input  logic [CY_BITS-1:0]   frame_height,
    input  logic [1:0]           mode,
    input  logic                 pal_we,
    input  logic [DATA_BITS-1:0] pal_waddr,
    input  logic [23:0]          pal_wdata,
    output logic                 read_en,
    output logic [ADDR_BITS-1:0] read_addr,
    input  logic [DATA_BITS-1:0] read_data,
    output logic [23:0]          rgb
);

    localparam int unsigned L         = RAM_LATENCY + 1;
    localparam int unsigned SHIFT     = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);
    localparam int unsigned ACT_W     = WIDTH * SCALE;
    localparam int unsigned ACT_H     = HEIGHT * SCALE;
    localparam int unsigned PAL_N     = 1 << DATA_BITS;
    localparam int unsigned FCNT_BITS = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
    localparam int unsigned REP       = (8 + DATA_BITS - 1) / DATA_BITS;

    // Index replicated MSB-first until 8 bits are filled; top 8 bits kept.
    function automatic logic [7:0] f_gray(input logic [DATA_BITS-1:0] d);
        logic [REP*DATA_BITS-1:0] rep;
        rep = {REP{d}};
        return rep[REP*DATA_BITS-1 -: 8];
    endfunction

    function automatic logic [23:0] f_pal_init(input int unsigned i);
        logic [7:0]  g;
        logic [23:0] c;
        g = f_gray(i[DATA_BITS-1:0]);
        c = {g, g, g};
        if (DATA_BITS == 4) begin
            case (i)
                0:       c = 24'h421e0f;
                1:       c = 24'h19071a;
                2:       c = 24'h09012f;
                3:       c = 24'h040449;
                4:       c = 24'h000764;
                5:       c = 24'h0c2c8a;
                6:       c = 24'h1852b1;
                7:       c = 24'h397dd1;
                8:       c = 24'h86b5e5;
                9:       c = 24'hd3ecf8;
                10:      c = 24'hf1e9bf;
                11:      c = 24'hf8c95f;
                12:      c = 24'hffaa00;
                13:      c = 24'hcc8000;
                14:      c = 24'h995700;
                default: c = 24'h6a3403;
            endcase
        end
        return c;
    endfunction

    logic                 r_read_en;
    logic [ADDR_BITS-1:0] r_read_addr;
    logic [L-1:0]         r_act;
    logic [1:0]           r_mode_q;
    logic [FCNT_BITS-1:0] r_fcnt;
    logic [DATA_BITS-1:0] r_rot;
    logic [23:0]          r_pal [PAL_N];
    logic [23:0]          r_rgb;

    logic [31:0]          w_px;
    logic [31:0]          w_py;
    logic                 w_active;
    logic [ADDR_BITS-1:0] w_addr;
    logic [L:0]           w_act_next;
    logic                 w_frame_start;
    logic [DATA_BITS-1:0] w_idx;
    logic [7:0]           w_gray;
    logic [23:0]          w_rgb_next;

    // Look-ahead position with line and frame wrap, kept 32 bits wide so no compare sees a truncated value.
    always_comb begin
        w_px = 32'(cx) + L;
        w_py = 32'(cy);
        if (w_px >= 32'(frame_width)) begin
            w_px = w_px - 32'(frame_width);
            w_py = 32'(cy) + 32'd1;
        end
        if (w_py >= 32'(frame_height)) begin
            w_py = '0;
        end
    end

    assign w_active      = (w_px < ACT_W) && (w_py < ACT_H);
    assign w_addr        = ADDR_BITS'((w_py >> SHIFT) * WIDTH + (w_px >> SHIFT));
    assign w_act_next    = {r_act, w_active};
    assign w_frame_start = (cx == '0) && (cy == '0);

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_read_en   <= 1'b0;
            r_read_addr <= '0;
            r_act       <= '0;
        end else begin
            r_read_en <= w_active;
            r_act     <= w_act_next[L-1:0];
            if (w_active) begin
                r_read_addr <= w_addr;
            end
        end
    end

    // Mode and rotation only change at frame start, so a frame is never shown in two modes.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_q <= 2'd0;
            r_fcnt   <= '0;
            r_rot    <= '0;
        end else if (w_frame_start) begin
            r_mode_q <= mode;
            if (r_fcnt == FCNT_BITS'(CYCLE_FRAMES - 1)) begin
                r_fcnt <= '0;
                if (r_mode_q == 2'd2) begin
                    r_rot <= r_rot + DATA_BITS'(1);
                end
            end else begin
                r_fcnt <= r_fcnt + FCNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < PAL_N; i++) begin
                r_pal[i[DATA_BITS-1:0]] <= f_pal_init(i);
            end
        end else if (pal_we) begin
            r_pal[pal_waddr] <= pal_wdata;
        end
    end

    always_comb begin
        w_idx      = (r_mode_q == 2'd2) ? (read_data + r_rot) : read_data;
        w_gray     = f_gray(read_data);
        w_rgb_next = BORDER_RGB;
        if (r_act[L-1]) begin
            case (r_mode_q)
                2'd1:    w_rgb_next = {w_gray, w_gray, w_gray};
                default: w_rgb_next = r_pal[w_idx];
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_rgb_next;
        end
    end

    assign read_en   = r_read_en;
    assign read_addr = r_read_addr;
    assign rgb       = r_rgb;

endmodule
